fft_twiddle_mult: RTL and testbench

- Pipelined complex multiplier for the radix-4 FFT datapath: Y = A × W.
- A is a packed signed complex data sample; W (WR + jWI) is a signed Q1.(TW-1) twiddle factor.
- Sits between butterfly stages; it rounds the result and saturates it back to the data width.

---
 rtl/fft_pkg.sv | 32 +++
 rtl/fft_round_sat.sv | 17 +
 rtl/fft_twiddle_mult.sv | 70 +++++++
 tb/tb_fft_twiddle_mult.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared widths, rounding constant, complex sample type and the DW saturation helper
// for the twiddle multiplier datapath.
package fft_pkg;

    localparam int DW   = 11;
    localparam int TW   = 16;
    localparam int FRAC = TW - 1;
    localparam int MW   = DW + TW;
    localparam int PW   = DW + TW + 1;
    localparam int SW   = PW - FRAC;

    localparam logic signed [PW-1:0] RND    = PW'(2 ** (FRAC - 1));
    localparam logic signed [SW-1:0] SAT_HI = SW'(2 ** (DW - 1) - 1);
    localparam logic signed [SW-1:0] SAT_LO = ~SAT_HI;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cplx_t;

    function automatic logic signed [DW-1:0] saturate_dw(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] c;
        if (v > SAT_HI)
            c = SAT_HI;
        else if (v < SAT_LO)
            c = SAT_LO;
        else
            c = v;
        return c[DW-1:0];
    endfunction

endpackage

// File: rtl/fft_round_sat.sv
// Round-half-up by 2^(TW-2), arithmetic shift by TW-1, then clamp one component to DW bits.
module fft_round_sat
    import fft_pkg::*;
(
    input  logic signed [PW-1:0] p_i,
    output logic signed [DW-1:0] y_o
);

    logic signed [PW-1:0] rnd;
    logic signed [SW-1:0] shifted;

    // PW bits leave headroom for the largest |product| plus the rounding constant
    assign rnd     = p_i + RND;
    assign shifted = SW'(rnd >>> FRAC);
    assign y_o     = saturate_dw(shifted);

endmodule

// File: rtl/fft_twiddle_mult.sv
// Three-stage pipelined complex multiply Y = A * W with rounding and saturation to DW.
module fft_twiddle_mult
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [2*DW-1:0]   A,
    input  logic [TW-1:0]     WR,
    input  logic [TW-1:0]     WI,
    input  logic              in_valid,
    output logic [2*DW-1:0]   Y,
    output logic              out_valid
);

    cplx_t a_in;
    assign a_in = A;

    logic signed [DW-1:0] ar_q, ai_q;
    logic signed [TW-1:0] wr_q, wi_q;
    logic signed [MW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic signed [MW-1:0] p_rr_d, p_ii_d, p_ri_d, p_ir_d;
    logic signed [PW-1:0] pr_d, pi_d;
    logic signed [DW-1:0] yr_d, yi_d, yr_q, yi_q;
    logic [2:0]           v_q;

    always_comb begin
        p_rr_d = MW'(ar_q) * MW'(wr_q);
        p_ii_d = MW'(ai_q) * MW'(wi_q);
        p_ri_d = MW'(ar_q) * MW'(wi_q);
        p_ir_d = MW'(ai_q) * MW'(wr_q);
        pr_d   = PW'(p_rr_q) - PW'(p_ii_q);
        pi_d   = PW'(p_ri_q) + PW'(p_ir_q);
    end

    fft_round_sat u_rs_re (.p_i(pr_d), .y_o(yr_d));
    fft_round_sat u_rs_im (.p_i(pi_d), .y_o(yi_d));

    // Data stages load unconditionally; only the valid shift register qualifies them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_q   <= '0;
            ai_q   <= '0;
            wr_q   <= '0;
            wi_q   <= '0;
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ri_q <= '0;
            p_ir_q <= '0;
            yr_q   <= '0;
            yi_q   <= '0;
            v_q    <= '0;
        end else begin
            ar_q   <= a_in.re;
            ai_q   <= a_in.im;
            wr_q   <= WR;
            wi_q   <= WI;
            p_rr_q <= p_rr_d;
            p_ii_q <= p_ii_d;
            p_ri_q <= p_ri_d;
            p_ir_q <= p_ir_d;
            yr_q   <= yr_d;
            yi_q   <= yi_d;
            v_q    <= {v_q[1:0], in_valid};
        end
    end

    assign Y         = {yr_q, yi_q};
    assign out_valid = v_q[2];

endmodule

// File: tb/tb_fft_twiddle_mult.sv
// Scoreboard bench for fft_twiddle_mult: stimulus pushes model results, a monitor pops on out_valid.
module tb_fft_twiddle_mult;

    localparam int DW = 11;
    localparam int TW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [2*DW-1:0]   A;
    logic [TW-1:0]     WR, WI;
    logic              in_valid;
    logic [2*DW-1:0]   Y;
    logic              out_valid;

    fft_twiddle_mult dut (
        .clk(clk), .rst(rst), .A(A), .WR(WR), .WI(WI),
        .in_valid(in_valid), .Y(Y), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int yr;
        int yi;
        int due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Exact complex product scaled by 2^-15, rounded half toward +inf, clamped to DW.
    function automatic int ref_comp(longint p);
        longint r;
        r = (p + 64'sd16384) >>> 15;
        if (r > 1023) r = 1023;
        if (r < -1024) r = -1024;
        return int'(r);
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic send(int ar, int ai, int wr, int wi, bit v);
        exp_t e;
        longint pr, pi;
        @(negedge clk);
        A        = {DW'(ar), DW'(ai)};
        WR       = TW'(wr);
        WI       = TW'(wi);
        in_valid = v;
        if (v) begin
            pr    = longint'(ar) * wr - longint'(ai) * wi;
            pi    = longint'(ar) * wi + longint'(ai) * wr;
            e.yr  = ref_comp(pr);
            e.yi  = ref_comp(pi);
            e.due = cyc + 3;
            q.push_back(e);
        end
    endtask

    function automatic int rnd_data();
        return int'($urandom_range(0, 2047)) - 1024;
    endfunction

    function automatic int rnd_tw();
        int s;
        s = int'($urandom_range(0, 7));
        if (s == 0) return -32768;
        if (s == 1) return 32767;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", 1, 0);
            end else begin
                e = q.pop_front();
                check("yr", int'($signed(Y[2*DW-1:DW])), e.yr);
                check("yi", int'($signed(Y[DW-1:0])), e.yi);
                check("latency", cyc, e.due);
            end
        end
    end

    initial begin
        bit pat[8] = '{1, 0, 1, 1, 0, 1, 1, 1};
        rst      = 1'b1;
        A        = '0;
        WR       = '0;
        WI       = '0;
        in_valid = 1'b0;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            A        = 22'($urandom);
            WR       = 16'($urandom);
            WI       = 16'($urandom);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("reset_y", int'(Y), 0);
            check("reset_valid", int'(out_valid), 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;

        send(2, 2, 32767, 32767, 1);
        send(100, -50, 32767, 0, 1);
        send(-1024, -1024, -32768, -32768, 1);
        send(1023, 0, 0, -32768, 1);
        send(1, 0, 16384, 0, 1);
        send(-1, 0, 16384, 0, 1);
        send(-1024, 1023, -32768, 32767, 1);

        for (int i = 0; i < 8; i++)
            send(rnd_data(), rnd_data(), rnd_tw(), rnd_tw(), pat[i]);

        for (int i = 0; i < 150; i++)
            send(rnd_data(), rnd_data(), rnd_tw(), rnd_tw(), $urandom_range(0, 3) != 0);

        for (int i = 0; i < 4; i++)
            send(rnd_data(), rnd_data(), rnd_tw(), rnd_tw(), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_y", int'(Y), 0);
        check("async_reset_valid", int'(out_valid), 0);
        q.delete();
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        send(0, 0, 0, 0, 0);
        send(2, 2, 32767, 32767, 1);
        for (int i = 0; i < 100; i++)
            send(rnd_data(), rnd_data(), rnd_tw(), rnd_tw(), $urandom_range(0, 1) != 0);

        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_pending", q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
